// File: rtl/sram_arbiter.sv
// Two-port round-robin arbiter in front of a single-port SRAM.
// Ports: clk/rst_n, req/we/addr/wdata per port A/B, gnt/done/rdata per port, sram_* bus, busy.
module sram_arbiter #(
  parameter int WAIT_CYC = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_a,
  input  logic       req_b,
  input  logic       we_a,
  input  logic       we_b,
  input  logic [7:0] addr_a,
  input  logic [7:0] addr_b,
  input  logic [7:0] wdata_a,
  input  logic [7:0] wdata_b,
  output logic       gnt_a,
  output logic       gnt_b,
  output logic       done_a,
  output logic       done_b,
  output logic [7:0] rdata_a,
  output logic [7:0] rdata_b,
  output logic       sram_cs,
  output logic       sram_wr,
  output logic       sram_rd,
  output logic [7:0] sram_addr,
  output logic [7:0] sram_din,
  input  logic [7:0] sram_dout,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STROBE,
    DONE
  } state_t;

  localparam logic [3:0] LAST = 4'(WAIT_CYC - 1);

  state_t     state;
  state_t     nxt;
  logic [3:0] cnt;
  logic       prio_b;
  logic       win_b;
  logic       we_q;
  logic [7:0] addr_q;
  logic [7:0] wdata_q;
  logic       pick_b;

  logic       o_gnt_a;
  logic       o_gnt_b;
  logic       o_done_a;
  logic       o_done_b;
  logic       o_cs;
  logic       o_wr;
  logic       o_rd;

  // B wins alone, or when both ask and A was served last.
  assign pick_b = req_b & (~req_a | prio_b);

  // Pin values are the registered image of the state just left,
  // so each phase shows on the bus one cycle after it is entered.
  always_comb begin
    nxt      = state;
    o_gnt_a  = 1'b0;
    o_gnt_b  = 1'b0;
    o_done_a = 1'b0;
    o_done_b = 1'b0;
    o_cs     = 1'b0;
    o_wr     = 1'b0;
    o_rd     = 1'b0;
    unique case (state)
      IDLE: begin
        if (req_a || req_b) nxt = SETUP;
      end
      SETUP: begin
        nxt     = STROBE;
        o_gnt_a = ~win_b;
        o_gnt_b = win_b;
        o_cs    = 1'b1;
      end
      STROBE: begin
        if (cnt == 4'd0) nxt = DONE;
        o_gnt_a = ~win_b;
        o_gnt_b = win_b;
        o_cs    = 1'b1;
        o_wr    = we_q;
        o_rd    = ~we_q;
      end
      DONE: begin
        nxt      = IDLE;
        o_gnt_a  = ~win_b;
        o_gnt_b  = win_b;
        o_done_a = ~win_b;
        o_done_b = win_b;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      prio_b    <= 1'b0;
      win_b     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= 8'h00;
      wdata_q   <= 8'h00;
      gnt_a     <= 1'b0;
      gnt_b     <= 1'b0;
      done_a    <= 1'b0;
      done_b    <= 1'b0;
      rdata_a   <= 8'h00;
      rdata_b   <= 8'h00;
      sram_cs   <= 1'b0;
      sram_wr   <= 1'b0;
      sram_rd   <= 1'b0;
      sram_addr <= 8'h00;
      sram_din  <= 8'h00;
      busy      <= 1'b0;
    end else begin
      state   <= nxt;
      busy    <= (nxt != IDLE);
      gnt_a   <= o_gnt_a;
      gnt_b   <= o_gnt_b;
      done_a  <= o_done_a;
      done_b  <= o_done_b;
      sram_cs <= o_cs;
      sram_wr <= o_wr;
      sram_rd <= o_rd;
      if (state == IDLE && (req_a || req_b)) begin
        win_b   <= pick_b;
        prio_b  <= ~pick_b;
        we_q    <= pick_b ? we_b : we_a;
        addr_q  <= pick_b ? addr_b : addr_a;
        wdata_q <= pick_b ? wdata_b : wdata_a;
      end
      if (state == SETUP) begin
        cnt       <= LAST;
        sram_addr <= addr_q;
        sram_din  <= wdata_q;
      end else if (state == STROBE && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      // sram_dout is valid in the last strobe cycle on the pins.
      if (state == DONE && !we_q) begin
        if (win_b) rdata_b <= sram_dout;
        else       rdata_a <= sram_dout;
      end
    end
  end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameter: WAIT_CYC, 1, SRAM strobe width in clock cycles, legal range 1..15.
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports: req_a / req_b  input  1  access request, port A / port B.
REQ-005 SHALL have ports: we_a / we_b  input  1  1 = write, 0 = read.
REQ-006 SHALL have ports: addr_a / addr_b  input  8  SRAM address.
REQ-007 SHALL have ports: wdata_a / wdata_b  input  8  write data.
REQ-008 SHALL have ports: gnt_a / gnt_b  output  1  port owns SRAM.
REQ-009 SHALL have ports: done_a / done_b  output  1  one-cycle completion pulse.
REQ-010 SHALL have ports: rdata_a / rdata_b  output  8  read data, held until the port's next read completes.
REQ-011 SHALL have ports: sram_cs, sram_wr, sram_rd  output  1 each  SRAM chip select, write strobe, read strobe.
REQ-012 SHALL have ports: sram_addr, sram_din  output  8 each  address and write data to SRAM.
REQ-013 SHALL have port: sram_dout  input  8  SRAM read data, valid while sram_cs & sram_rd.
REQ-014 SHALL have port: busy  output  1  high whenever state != IDLE.

Function
REQ-015 SHALL implement FSM IDLE -> SETUP -> STROBE -> DONE -> IDLE; every output registered.
REQ-016 IDLE: if any req is high, SHALL select a winner, latch its we/addr/wdata, set its gnt, and go to SETUP; otherwise stay in IDLE.
REQ-017 Arbitration SHALL be round-robin: a lone requester wins; on simultaneous requests, the port not served last wins; after reset, A has priority.
REQ-018 SETUP: SHALL drive sram_cs=1, sram_addr and sram_din from the latched values, sram_wr=sram_rd=0; lasts exactly 1 cycle.
REQ-019 STROBE: SHALL hold sram_cs=1 and assert sram_wr (write) or sram_rd (read, never both) for exactly WAIT_CYC cycles using a 4-bit counter.
REQ-020 On a read, SHALL capture sram_dout into the winner's rdata on the final STROBE edge; the other port's rdata is unchanged.
REQ-021 DONE: SHALL drive sram_cs=sram_wr=sram_rd=0, pulse the winner's done for 1 cycle, then clear gnt and return to IDLE.
REQ-022 Latency: done SHALL rise WAIT_CYC+2 rising edges after the edge that samples req in IDLE; minimum request-to-request spacing is WAIT_CYC+3 cycles.
REQ-023 gnt SHALL stay high from SETUP through DONE inclusive; gnt_a and gnt_b SHALL never be high together.
REQ-024 Latched we/addr/wdata SHALL NOT change mid-transaction; input changes or req deassertion after the grant SHALL be ignored, and the transaction completes.
REQ-025 A req still high in the IDLE cycle after DONE SHALL be treated as a new request; requesters drop req on done to avoid a repeat access.
REQ-026 sram_addr and sram_din SHALL hold their last value in IDLE; only sram_cs qualifies them.

Reset
REQ-027 On rst_n=0, SHALL go to IDLE immediately without waiting for clk, with gnt_*, done_*, sram_cs, sram_wr, sram_rd and busy = 0, sram_addr = sram_din = 0x00, rdata_* = 0x00, counter = 0, and priority to A.
REQ-028 Reset during SETUP or STROBE SHALL abort the access, drop the strobes asynchronously, and produce no done pulse.
REQ-029 After rst_n rises, the first req SHALL be sampled on the first following rising edge.

Verification
REQ-030 WAIT_CYC=1; A writes addr 0x03 data 0xB5 -> sram_wr high for 1 cycle with sram_addr=0x03 and sram_din=0xB5; done_a 3 edges after req sampled.
REQ-031 A then reads 0x03 (SRAM model) -> sram_rd high for 1 cycle; rdata_a=0xB5 together with done_a; rdata_b remains 0x00.
REQ-032 After reset, req_a and req_b rise together (both writes, 0x10/0x11 and 0x20/0x22) -> A served first, B second; gnt never overlaps; SRAM holds 0x11 at 0x10 and 0x22 at 0x20.
REQ-033 req_a held high continuously, req_b raised -> grants alternate A, B, A, B; B waits at most one transaction.
REQ-034 WAIT_CYC=3; read -> sram_rd high for exactly 3 cycles; done 5 edges after req sampled.
REQ-035 rst_n pulsed low mid-STROBE -> sram_cs, sram_wr, sram_rd and gnt drop before the next edge; no done; a new req is served normally afterwards.
